// File: rtl/serial_alu.sv
// ============================================================================
// Module   : serial_alu
// Purpose  : Bit-serial MIPS ALU, one slice reused LSB-first over WIDTH cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             c_out
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               cout_q, cout_d;

    logic               is_sub;
    logic               bit_a, bit_b, bit_bb;
    logic               sum;
    logic               slice;
    logic               last_bit;

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- one-bit slice ----------------
    always_comb begin
        is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
        last_bit = (cnt_q == LAST_IDX);
        bit_a    = a_q[cnt_q];
        bit_b    = b_q[cnt_q];
        bit_bb   = bit_b ^ is_sub;
        sum      = bit_a ^ bit_bb ^ carry_q;
        carry_d  = (bit_a & bit_bb) | (bit_a & carry_q) | (bit_bb & carry_q);

        case (op_q)
            OP_AND:                 slice = bit_a & bit_b;
            OP_OR:                  slice = bit_a | bit_b;
            OP_NOR:                 slice = ~(bit_a | bit_b);
            OP_ADD, OP_SUB, OP_SLT: slice = sum;
            default:                slice = 1'b0;
        endcase

        shadow_d = {slice, shadow_q[WIDTH-1:1]};
    end

    // Final values, only meaningful while the MSB is being processed:
    // carry_q is then the carry into the MSB, carry_d the carry out.
    always_comb begin
        result_d = shadow_d;
        ovf_d    = 1'b0;
        cout_d   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                ovf_d  = carry_q ^ carry_d;
                cout_d = carry_d;
            end
            OP_SLT: begin
                result_d    = '0;
                result_d[0] = sum ^ (carry_q ^ carry_d);
                cout_d      = carry_d;
            end
            OP_AND, OP_OR, OP_NOR: ;
            default: result_d = '0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                cnt_q   <= '0;
                carry_q <= (op == OP_SUB) || (op == OP_SLT);
            end
        end else if (state_q == S_RUN) begin
            carry_q  <= carry_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_q + 1'b1;
            if (last_bit) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                cout_q   <= cout_d;
            end
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign overflow = ovf_q;
    assign c_out    = cout_q;
    assign zero     = (result_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_alu.sv
// ============================================================================
// Module   : tb_serial_alu
// Purpose  : Self-checking bench for serial_alu (WIDTH=8) against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_alu;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         busy, done, zero, overflow, c_out;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state: cycles since the accepting edge, -1 when idle.
    int           since = -1;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_ovf = 1'b0, p_ovf = 1'b0;
    logic         m_cout = 1'b0, p_cout = 1'b0;

    serial_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .c_out    (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void alu_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic ov, output logic co);
        logic [W:0] s;
        r  = '0;
        ov = 1'b0;
        co = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b100: r = ~(x | y);
            3'b010: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b110: begin
                s  = {1'b0, x} + {1'b0, ~y} + 1;
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b111: begin
                s  = {1'b0, x} + {1'b0, ~y} + 1;
                co = s[W];
                r  = ($signed(x) < $signed(y)) ? 1 : 0;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            since  = -1;
            m_res  = '0;
            m_ovf  = 1'b0;
            m_cout = 1'b0;
        end else if (since == W) begin
            since = -1;
        end else if (since >= 0) begin
            since++;
            if (since == W) begin
                m_res  = p_res;
                m_ovf  = p_ovf;
                m_cout = p_cout;
            end
        end else if (start) begin
            since = 0;
            alu_model(op, a, b, p_res, p_ovf, p_cout);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",     {31'd0, busy},     {31'd0, (since >= 0) && (since < W)});
            chk("cyc_done",     {31'd0, done},     {31'd0, since == W});
            chk("cyc_result",   {24'd0, result},   {24'd0, m_res});
            chk("cyc_zero",     {31'd0, zero},     {31'd0, m_res == '0});
            chk("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("cyc_c_out",    {31'd0, c_out},    {31'd0, m_cout});
        end
    end

    task automatic wait_done(input string nm, output int n);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic eo, input logic ec);
        int n;
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        op = o;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom);
        wait_done(nm, n);
        chk({nm, "_latency"},  n, 9);
        chk({nm, "_result"},   {24'd0, result},   {24'd0, er});
        chk({nm, "_zero"},     {31'd0, zero},     {31'd0, er == '0});
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({nm, "_c_out"},    {31'd0, c_out},    {31'd0, ec});
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy",   {31'd0, busy},     0);
        chk("rst_done",   {31'd0, done},     0);
        chk("rst_result", {24'd0, result},   0);
        chk("rst_zero",   {31'd0, zero},     1);
        chk("rst_ovf",    {31'd0, overflow}, 0);
        chk("rst_cout",   {31'd0, c_out},    0);
        chk_en = 1'b1;

        run_op("add_ovf",   3'b010, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
        run_op("sub_eq",    3'b110, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1);
        run_op("sub_neg",   3'b110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
        run_op("slt_neg",   3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1);
        run_op("slt_ovf",   3'b111, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0);
        run_op("slt_eq",    3'b111, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1);
        run_op("and",       3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        run_op("or",        3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
        run_op("nor",       3'b100, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0);
        run_op("add_carry", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
        run_op("undef",     3'b011, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0);

        // start re-pulsed during RUN must not disturb the running add
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; op = 3'b010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b110;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", n);
        chk("ignore_result", {24'd0, result}, 32'h30);

        // reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; op = 3'b010;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",   {31'd0, busy},   0);
        chk("abort_done",   {31'd0, done},   0);
        chk("abort_result", {24'd0, result}, 0);
        chk("abort_zero",   {31'd0, zero},   1);
        repeat (10) @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 0);
        run_op("add_after", 3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // start held high through DONE: next accept at the first IDLE edge
        @(negedge clk);
        start = 1'b1; a = 8'h03; b = 8'h04; op = 3'b010;
        @(negedge clk);
        wait_done("b2b_first", n);
        chk("b2b_first_result", {24'd0, result}, 32'h07);
        a = 8'h05; b = 8'h06;
        @(negedge clk);
        chk("b2b_idle_busy", {31'd0, busy}, 0);
        chk("b2b_idle_done", {31'd0, done}, 0);
        @(negedge clk);
        chk("b2b_accept_busy", {31'd0, busy}, 1);
        start = 1'b0;
        wait_done("b2b_second", n);
        chk("b2b_second_result", {24'd0, result}, 32'h0B);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
